seg7_serial_driver: RTL and testbench
=====================================

// Module: seg7_serial_driver
// PURPOSE
//  Display stage after the 8-channel display multiplexer. Takes a 32-bit display word, decimal points and blink mask.
//  Renders them as 64 segment bits: 8 digits x 8 bits, active-low.
//  Shifts the bits serially into the board's 7-seg shift-register chain (seg_clk/seg_sout/seg_pen/seg_clrn).
//  A frame is sent on each start rising edge.
// PARAMETERS
//  CLK_DIV        2         clk cycles per seg_clk half-period (>=1)
//  REFRESH_PERIOD 1000000   clk cycles between auto frames (SEG7_DRV_REFRESH_EN only)
// PORTS
//  clk       in   1   system clock
//  rst       in   1   synchronous reset, active-high
//  start     in   1   frame request; rising edge sampled
//  hex_mode  in   1   1: decode hexs as 8 hex digits; 0: hexs is raw segment data
//  flash     in   1   blink phase; 1 blanks digits selected by les
//  hexs      in   32  display word; digit7 = hexs[31:28]
//  points    in   8   decimal point per digit, 1 = lit; bit i -> digit i
//  les       in   8   blink enable per digit; bit i -> digit i
//  seg_clk   out  1   serial clock; chain samples seg_sout on rising edge
//  seg_sout  out  1   serial data
//  seg_pen   out  1   parallel-output enable; 0 while shifting
//  seg_clrn  out  1   chain clear, active-low
//  busy      out  1   frame in progress
// BEHAVIOUR
//  Reset values: seg_clk=0, seg_sout=0, seg_pen=0, seg_clrn=0, busy=0, state IDLE, start_d=0.
//  seg_clrn rises to 1 on the first cycle after rst deasserts and holds there.
//  Edge detect: start_d registered each cycle. Edge in cycle N means start=1 and start_d=0.
//  FSM: IDLE -> LOAD -> SHIFT_LO <-> SHIFT_HI -> DONE -> IDLE.
//  IDLE, on edge at cycle N: go to LOAD at N+1.
//  LOAD, 1 cycle:
//    - latch 64-bit frame; busy=1; seg_pen=0
//    - seg_sout=frame[63]; bit_cnt=0
//  SHIFT_LO: seg_clk=0 for CLK_DIV cycles, then go to SHIFT_HI.
//  SHIFT_HI: seg_clk=1 for CLK_DIV cycles, then:
//    - bit_cnt=63: go to DONE
//    - otherwise: bit_cnt++, seg_sout=next bit (MSB first), go to SHIFT_LO
//  seg_sout changes only at the SHIFT_HI->SHIFT_LO transition. It is stable for the whole high phase.
//  DONE, 1 cycle: seg_clk=0, seg_pen=1, busy=0 from the next cycle. Then IDLE.
//  seg_pen stays 1 in IDLE until the next LOAD.
//  Busy length: 2 + 128*CLK_DIV cycles (258 at default).
//  Frame byte order: digit7 byte first, digit0 byte last.
//  Frame bit order within a byte: {dp,g,f,e,d,c,b,a}, bit7 (dp) first.
//  hex_mode=1, digit i:
//    - segments = decode(hexs[4i+3:4i]), active-low
//    - dp bit = ~points[i]
//    - if les[i]&flash at LOAD: whole byte = 8'hFF (blank)
//  Decode table:
//    - 0:C0  1:F9  2:A4  3:B0  4:99  5:92  6:82  7:F8
//    - 8:80  9:90  A:88  b:83  C:C6  d:A1  E:86  F:8E
//    - dp=1 in all entries; the dp bit is then overridden as above
//  hex_mode=0: frame = {hexs, hexs}, bits passed unmodified. points and les are ignored.
//  Inputs are sampled only in LOAD. Changes mid-frame do not affect the frame being shifted.
//  start edge while busy (LOAD..DONE): ignored, not queued. start held high produces exactly one frame.
//  rst mid-frame: next cycle all outputs take reset values; the partial frame is abandoned.
//  Edge detection resumes one cycle after rst deasserts.
// CONFIGURATION
//  SEG7_DRV_REFRESH_EN defined:
//    - free-running counter triggers a frame every REFRESH_PERIOD cycles, in addition to start edges
//    - a refresh tick while busy is dropped
//    - counter resets to 0 on rst
//  Undefined: frames only on start edges; no refresh counter is synthesised.
// TESTING
//  1. Release rst; pulse start=1 for 1 cycle; hex_mode=1, hexs=32'h0123_89AF, points=0, les=0.
//     -> captured 64 bits on seg_clk rising edges = C0 F9 A4 B0 80 90 88 8E
//     -> busy high exactly 258 cycles; seg_pen 0 during shift, 1 after
//  2. hex_mode=1, hexs=32'h8888_8888, points=8'h01, les=8'h80, flash=1.
//     -> byte0 (digit7) = FF; bytes1-6 = 80; byte7 (digit0) = 00
//  3. hex_mode=0, hexs=32'hDEAD_BEEF -> serial stream DE AD BE EF DE AD BE EF.
//  4. Second start edge at cycle 50 of a frame; change hexs mid-frame.
//     -> exactly one frame, containing the LOAD-time data; no second frame
//  5. Assert rst at bit 20 of a frame.
//     -> next cycle seg_clk=0, seg_sout=0, seg_pen=0, seg_clrn=0, busy=0
//     -> after release, a new start yields a complete correct frame
//  6. SEG7_DRV_REFRESH_EN with REFRESH_PERIOD=1000, start tied 0.
//     -> frames begin every 1000 cycles, each 258 busy cycles

Source files
------------

// File: rtl/seg7_serial_driver.sv
// seg7_serial_driver: renders a 32-bit display word into 64 active-low
// segment bits and shifts them MSB-first into the board's 7-segment
// shift-register chain (seg_clk / seg_sout / seg_pen / seg_clrn).
// Optional feature macro: SEG7_DRV_REFRESH_EN adds a free-running refresh
// counter that requests a frame every REFRESH_PERIOD clock cycles.
module seg7_serial_driver #(
  parameter int unsigned CLK_DIV        = 2,
  parameter int unsigned REFRESH_PERIOD = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        hex_mode,
  input  logic        flash,
  input  logic [31:0] hexs,
  input  logic [7:0]  points,
  input  logic [7:0]  les,
  output logic        seg_clk,
  output logic        seg_sout,
  output logic        seg_pen,
  output logic        seg_clrn,
  output logic        busy
);

  localparam int unsigned FRAME_W = 64;
  localparam int unsigned BIT_W   = 6;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLK_DIV - 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD     = 3'd1;
  localparam logic [2:0] ST_SHIFT_LO = 3'd2;
  localparam logic [2:0] ST_SHIFT_HI = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  logic [2:0]         state_q, state_nxt;
  logic [DIV_W-1:0]   div_q, div_nxt;
  logic [BIT_W-1:0]   bit_q, bit_nxt;
  logic [FRAME_W-1:0] frame_q, frame_nxt;
  logic               seg_clk_nxt, seg_sout_nxt, seg_pen_nxt, busy_nxt;
  logic               start_d;
  logic               start_edge_c;
  logic               trigger_c;
  logic [FRAME_W-1:0] frame_c;

  // Hex nibble to active-low {dp,g,f,e,d,c,b,a}; dp left dark here.
  function automatic logic [7:0] decode_hex(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

  // Start edge detector register.
  always_ff @(posedge clk) begin
    if (rst) start_d <= 1'b0;
    else     start_d <= start;
  end

  assign start_edge_c = start & ~start_d;

`ifdef SEG7_DRV_REFRESH_EN
  localparam int unsigned REF_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_PERIOD - 1);

  logic [REF_W-1:0] refresh_q;
  logic             refresh_tick_c;

  // Free-running refresh counter; ticks once per REFRESH_PERIOD cycles.
  always_ff @(posedge clk) begin
    if (rst)                    refresh_q <= '0;
    else if (refresh_q == REF_LAST) refresh_q <= '0;
    else                        refresh_q <= refresh_q + REF_W'(1);
  end

  assign refresh_tick_c = (refresh_q == REF_LAST);
  assign trigger_c      = start_edge_c | refresh_tick_c;
`else
  assign trigger_c      = start_edge_c;
`endif

  // Frame image built from the live inputs; only captured in LOAD.
  always_comb begin
    frame_c = {hexs, hexs};
    if (hex_mode) begin
      for (int i = 0; i < 8; i++) begin
        if (les[i] && flash) frame_c[8*i +: 8] = 8'hFF;
        else                 frame_c[8*i +: 8] = {~points[i], decode_hex(hexs[4*i +: 4])[6:0]};
      end
    end
  end

  // Chain clear: held low in reset, released the cycle after.
  always_ff @(posedge clk) begin
    if (rst) seg_clrn <= 1'b0;
    else     seg_clrn <= 1'b1;
  end

  // State, counters, frame shifter and registered serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      frame_q  <= '0;
      seg_clk  <= 1'b0;
      seg_sout <= 1'b0;
      seg_pen  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      div_q    <= div_nxt;
      bit_q    <= bit_nxt;
      frame_q  <= frame_nxt;
      seg_clk  <= seg_clk_nxt;
      seg_sout <= seg_sout_nxt;
      seg_pen  <= seg_pen_nxt;
      busy     <= busy_nxt;
    end
  end

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_nxt    = state_q;
    div_nxt      = div_q;
    bit_nxt      = bit_q;
    frame_nxt    = frame_q;
    seg_clk_nxt  = seg_clk;
    seg_sout_nxt = seg_sout;
    seg_pen_nxt  = seg_pen;
    busy_nxt     = busy;

    case (state_q)
      ST_IDLE: begin
        if (trigger_c) begin
          state_nxt   = ST_LOAD;
          busy_nxt    = 1'b1;
          seg_pen_nxt = 1'b0;
        end
      end

      ST_LOAD: begin
        frame_nxt    = frame_c;
        seg_sout_nxt = frame_c[FRAME_W-1];
        bit_nxt      = '0;
        div_nxt      = '0;
        seg_clk_nxt  = 1'b0;
        state_nxt    = ST_SHIFT_LO;
      end

      ST_SHIFT_LO: begin
        if (div_q == LAST_DIV) begin
          div_nxt     = '0;
          seg_clk_nxt = 1'b1;
          state_nxt   = ST_SHIFT_HI;
        end else begin
          div_nxt = div_q + DIV_W'(1);
        end
      end

      ST_SHIFT_HI: begin
        if (div_q == LAST_DIV) begin
          div_nxt     = '0;
          seg_clk_nxt = 1'b0;
          if (bit_q == LAST_BIT) begin
            seg_pen_nxt = 1'b1;
            state_nxt   = ST_DONE;
          end else begin
            // Data only moves on the falling edge, so it is stable while high.
            bit_nxt      = bit_q + BIT_W'(1);
            frame_nxt    = {frame_q[FRAME_W-2:0], 1'b0};
            seg_sout_nxt = frame_q[FRAME_W-2];
            state_nxt    = ST_SHIFT_LO;
          end
        end else begin
          div_nxt = div_q + DIV_W'(1);
        end
      end

      ST_DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt   = ST_IDLE;
        busy_nxt    = 1'b0;
        seg_clk_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_seg7_serial_driver.sv
// Self-checking bench for seg7_serial_driver: random and directed frames
// compared against a byte-level reference model of the display encoding.
module tb_seg7_serial_driver;

  localparam int unsigned CLK_DIV = 2;
`ifdef SEG7_DRV_REFRESH_EN
  localparam int unsigned REFRESH_PERIOD = 1000;
`else
  localparam int unsigned REFRESH_PERIOD = 1000000;
`endif
  localparam int BUSY_LEN = 2 + 128 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        hex_mode;
  logic        flash;
  logic [31:0] hexs;
  logic [7:0]  points;
  logic [7:0]  les;
  logic        seg_clk, seg_sout, seg_pen, seg_clrn, busy;

  int n_checks = 0;
  int n_fail   = 0;

  seg7_serial_driver #(.CLK_DIV(CLK_DIV), .REFRESH_PERIOD(REFRESH_PERIOD)) dut (
    .clk(clk), .rst(rst), .start(start), .hex_mode(hex_mode), .flash(flash),
    .hexs(hexs), .points(points), .les(les),
    .seg_clk(seg_clk), .seg_sout(seg_sout), .seg_pen(seg_pen),
    .seg_clrn(seg_clrn), .busy(busy)
  );

  always #5 clk = ~clk;

  // Monitors
  bit cap[$];
  int busy_cycles = 0;
  int frames      = 0;
  int pen_bad     = 0;
  int sout_bad    = 0;
  int cyc         = 0;
  int starts[$];
  logic busy_prev = 1'b0;
  logic clk_prev  = 1'b0;
  logic sout_prev = 1'b0;

  always @(posedge seg_clk) cap.push_back(seg_sout);

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cycles++;
    if (busy === 1'b1 && busy_prev !== 1'b1) begin
      frames++;
      starts.push_back(cyc);
    end
    if (seg_clk === 1'b1 && seg_pen !== 1'b0) pen_bad++;
    if (seg_clk === 1'b1 && clk_prev === 1'b1 && seg_sout !== sout_prev) sout_bad++;
    busy_prev = busy;
    clk_prev  = seg_clk;
    sout_prev = seg_sout;
  end

  // Reference model: byte list digit7..digit0, each byte {dp,g..a} active-low.
  function automatic logic [63:0] model_frame(input logic hm, input logic [31:0] h,
                                              input logic [7:0] p, input logic [7:0] l,
                                              input logic f);
    logic [7:0]  table_seg [16];
    logic [63:0] r;
    logic [7:0]  b;
    int          nib;
    table_seg = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    if (!hm) return {h, h};
    r = '0;
    for (int d = 7; d >= 0; d--) begin
      nib = int'((h >> (4 * d)) & 32'hF);
      b   = table_seg[nib];
      if (p[d]) b = b - 8'h80;
      if (l[d] && f) b = 8'hFF;
      r = (r << 8) | 64'(b);
    end
    return r;
  endfunction

  function automatic logic [63:0] captured_word();
    logic [63:0] v = '0;
    for (int i = 0; i < cap.size() && i < 64; i++) v = {v[62:0], cap[i]};
    return v;
  endfunction

  task automatic set_inputs(input logic hm, input logic [31:0] h, input logic [7:0] p,
                            input logic [7:0] l, input logic f);
    hex_mode = hm; hexs = h; points = p; les = l; flash = f;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Bounded wait for a frame to start and finish; ok=0 on timeout.
  task automatic wait_frame(output bit ok);
    int t = 0;
    ok = 1'b1;
    while (busy !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    if (busy !== 1'b1) ok = 1'b0;
    t = 0;
    while (busy !== 1'b0 && t < 2000) begin @(negedge clk); t++; end
    if (busy !== 1'b0) ok = 1'b0;
  endtask

  task automatic send_frame(output logic [63:0] got, output int bcyc, output bit ok);
    cap.delete();
    busy_cycles = 0;
    pulse_start();
    wait_frame(ok);
    @(negedge clk);
    got  = captured_word();
    bcyc = busy_cycles;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    set_inputs(1'b1, 32'h0, 8'h0, 8'h0, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({seg_clk, seg_sout, seg_pen, seg_clrn, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 00000", {seg_clk, seg_sout, seg_pen, seg_clrn, busy});
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (seg_clrn !== 1'b1) begin
      n_fail++; $display("FAIL clrn_release: got %b required 1", seg_clrn);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_directed();
    logic [63:0] got, exp_const [3];
    logic [31:0] h [3];
    logic [7:0]  p [3], l [3];
    logic        hm [3], f [3];
    int          bcyc;
    bit          ok;
    h  = '{32'h0123_89AF, 32'h8888_8888, 32'hDEAD_BEEF};
    p  = '{8'h00, 8'h01, 8'h5A};
    l  = '{8'h00, 8'h80, 8'hFF};
    f  = '{1'b0, 1'b1, 1'b1};
    hm = '{1'b1, 1'b1, 1'b0};
    exp_const = '{64'hC0F9A4B0_8090888E, 64'hFF808080_80808000, 64'hDEADBEEF_DEADBEEF};
    for (int k = 0; k < 3; k++) begin
      set_inputs(hm[k], h[k], p[k], l[k], f[k]);
      send_frame(got, bcyc, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL directed%0d_timeout: frame did not complete", k); end
      n_checks++;
      if (got !== exp_const[k]) begin
        n_fail++; $display("FAIL directed%0d_data: got %h required %h", k, got, exp_const[k]);
      end
      n_checks++;
      if (got !== model_frame(hm[k], h[k], p[k], l[k], f[k])) begin
        n_fail++; $display("FAIL directed%0d_model: got %h required %h", k, got,
                           model_frame(hm[k], h[k], p[k], l[k], f[k]));
      end
      n_checks++;
      if (cap.size() != 64) begin
        n_fail++; $display("FAIL directed%0d_bitcount: got %0d required 64", k, cap.size());
      end
      n_checks++;
      if (bcyc != BUSY_LEN) begin
        n_fail++; $display("FAIL directed%0d_busy_len: got %0d required %0d", k, bcyc, BUSY_LEN);
      end
      n_checks++;
      if (seg_pen !== 1'b1) begin
        n_fail++; $display("FAIL directed%0d_pen_after: got %b required 1", k, seg_pen);
      end
    end
    n_checks++;
    if (pen_bad != 0 || sout_bad != 0) begin
      n_fail++; $display("FAIL shift_phase: pen_high_while_shifting=%0d sout_changed_while_high=%0d required 0/0",
                         pen_bad, sout_bad);
    end
  endtask

  task automatic test_random();
    logic [63:0] got, exp;
    logic [31:0] h;
    logic [7:0]  p, l;
    logic        hm, f;
    int          bcyc;
    bit          ok;
    for (int k = 0; k < 8; k++) begin
      h  = $urandom;
      p  = 8'($urandom_range(0, 255));
      l  = 8'($urandom_range(0, 255));
      hm = 1'($urandom_range(0, 1));
      f  = 1'($urandom_range(0, 1));
      set_inputs(hm, h, p, l, f);
      exp = model_frame(hm, h, p, l, f);
      send_frame(got, bcyc, ok);
      n_checks++;
      if (!ok || got !== exp || bcyc != BUSY_LEN) begin
        n_fail++; $display("FAIL random%0d: ok=%0d data %h busy %0d required data %h busy %0d",
                           k, ok, got, bcyc, exp, BUSY_LEN);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] got, exp;
    int          f0;
    bit          ok;
    set_inputs(1'b1, 32'h4567_BCDE, 8'h81, 8'h00, 1'b0);
    exp = model_frame(1'b1, 32'h4567_BCDE, 8'h81, 8'h00, 1'b0);
    cap.delete();
    f0 = frames;
    pulse_start();
    repeat (48) @(negedge clk);
    start = 1'b1; hexs = 32'h1111_1111; points = 8'hFF; hex_mode = 1'b0;
    @(negedge clk) start = 1'b0;
    wait_frame(ok);
    repeat (20) @(negedge clk);
    got = captured_word();
    n_checks++;
    if (!ok || frames - f0 != 1) begin
      n_fail++; $display("FAIL b2b_frames: ok=%0d got %0d frames required 1", ok, frames - f0);
    end
    n_checks++;
    if (got !== exp || cap.size() != 64) begin
      n_fail++; $display("FAIL b2b_data: got %h (%0d bits) required %h (64 bits)", got, cap.size(), exp);
    end
    // start held high across and beyond a frame yields one frame
    set_inputs(1'b0, 32'hCAFE_F00D, 8'h00, 8'h00, 1'b0);
    cap.delete();
    f0 = frames;
    @(negedge clk) start = 1'b1;
    wait_frame(ok);
    repeat (30) @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (!ok || frames - f0 != 1 || captured_word() !== 64'hCAFEF00D_CAFEF00D) begin
      n_fail++; $display("FAIL held_start: ok=%0d frames %0d data %h required 1 frame data cafef00dcafef00d",
                         ok, frames - f0, captured_word());
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [63:0] got, exp;
    int          t, bcyc;
    bit          ok;
    set_inputs(1'b1, 32'hFEDC_BA98, 8'h3C, 8'h00, 1'b0);
    cap.delete();
    pulse_start();
    t = 0;
    while (cap.size() < 20 && t < 500) begin @(negedge clk); t++; end
    n_checks++;
    if (cap.size() < 20) begin
      n_fail++; $display("FAIL midrst_reach: got %0d bits required 20", cap.size());
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({seg_clk, seg_sout, seg_pen, seg_clrn, busy} !== 5'b0) begin
      n_fail++; $display("FAIL midrst_outputs: got %b required 00000", {seg_clk, seg_sout, seg_pen, seg_clrn, busy});
    end
    rst = 1'b0;
    @(negedge clk);
    set_inputs(1'b1, 32'h0F1E_2D3C, 8'hA5, 8'h0F, 1'b1);
    exp = model_frame(1'b1, 32'h0F1E_2D3C, 8'hA5, 8'h0F, 1'b1);
    send_frame(got, bcyc, ok);
    n_checks++;
    if (!ok || got !== exp || cap.size() != 64 || bcyc != BUSY_LEN) begin
      n_fail++; $display("FAIL midrst_recover: ok=%0d data %h bits %0d busy %0d required %h 64 %0d",
                         ok, got, cap.size(), bcyc, exp, BUSY_LEN);
    end
  endtask

`ifdef SEG7_DRV_REFRESH_EN
  task automatic test_refresh();
    int t = 0, b0;
    bit ok;
    start = 1'b0;
    while (frames < 1 && t < 3000) begin @(negedge clk); t++; end
    wait_frame(ok);
    b0 = busy_cycles;
    starts.delete();
    t = 0;
    while (frames < 4 && t < 5000) begin @(negedge clk); t++; end
    wait_frame(ok);
    n_checks++;
    if (!ok || starts.size() != 3) begin
      n_fail++; $display("FAIL refresh_frames: ok=%0d got %0d frames required 3", ok, starts.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_checks++;
        if (starts[i] - starts[i-1] != int'(REFRESH_PERIOD)) begin
          n_fail++; $display("FAIL refresh_period%0d: got %0d required %0d", i,
                             starts[i] - starts[i-1], REFRESH_PERIOD);
        end
      end
    end
    n_checks++;
    if (busy_cycles - b0 != 3 * BUSY_LEN) begin
      n_fail++; $display("FAIL refresh_busy: got %0d required %0d", busy_cycles - b0, 3 * BUSY_LEN);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef SEG7_DRV_REFRESH_EN
    test_refresh();
`else
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
